// File: rtl/button_event_controller.sv
// -----------------------------------------------------------------------------
// button_event_controller
//
// Front end for the active-low push-buttons. One shared sampling counter sets
// the debounce time base for every channel. A small FSM per button turns the
// samples into PRESS and auto-REPEAT events. A round-robin arbiter serialises
// those events onto one valid/ready event port.
//
// Parameters
//   N               number of button channels (2..16)
//   SAMPLING_PERIOD a sample is taken every SAMPLING_PERIOD+1 clocks
//   REPEAT_DELAY    samples held before the first REPEAT
//   REPEAT_RATE     samples between later REPEATs (>= 1)
//
// Ports
//   clk         sole clock, all state on posedge
//   rst         asynchronous, active-high reset
//   i_btn_n     raw button levels, active-low, asynchronous to clk
//   o_ev_valid  an event is presented
//   i_ev_ready  consumer takes the event when o_ev_valid & i_ev_ready
//   o_ev_id     button index of the presented event
//   o_ev_kind   0 = PRESS, 1 = REPEAT
//   o_dropped   one-cycle pulse: a new event overwrote an unserviced one
// -----------------------------------------------------------------------------
module button_event_controller #(
    parameter int unsigned N               = 4,
    parameter int unsigned SAMPLING_PERIOD = 1250000 - 1,
    parameter int unsigned REPEAT_DELAY    = 50,
    parameter int unsigned REPEAT_RATE     = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         i_btn_n,
    output logic                 o_ev_valid,
    input  logic                 i_ev_ready,
    output logic [$clog2(N)-1:0] o_ev_id,
    output logic                 o_ev_kind,
    output logic                 o_dropped
);

    localparam int unsigned IW       = $clog2(N);
    localparam int unsigned CW       = $clog2(SAMPLING_PERIOD + 1);
    localparam int unsigned HOLD_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned HW       = $clog2(HOLD_MAX + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HELD = 2'd1;
    localparam logic [1:0] ST_RPT  = 2'd2;

    // ------------------------------------------------------------------
    // Synchroniser and shared time base
    // ------------------------------------------------------------------
    logic [N-1:0]    r_sync1;
    logic [N-1:0]    r_sync2;
    logic [N-1:0]    r_s;
    logic [CW-1:0]   r_cnt;
    logic            r_step;
    logic            w_sample;

    assign w_sample = (r_cnt == CW'(SAMPLING_PERIOD));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= i_btn_n;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_s    <= '1;
            r_step <= 1'b0;
        end else begin
            r_cnt  <= w_sample ? '0 : r_cnt + 1'b1;
            r_step <= w_sample;
            if (w_sample) begin
                r_s <= r_sync2;
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-button press / repeat FSMs
    // ------------------------------------------------------------------
    logic [1:0]    r_state     [N];
    logic [HW-1:0] r_hold      [N];
    logic [1:0]    w_state_nxt [N];
    logic [HW-1:0] w_hold_nxt  [N];
    logic [N-1:0]  w_post;
    logic [N-1:0]  w_post_kind;

    always_comb begin
        logic [HW-1:0] hold_inc;
        hold_inc    = '0;
        w_post      = '0;
        w_post_kind = '0;
        for (int unsigned i = 0; i < N; i++) begin
            w_state_nxt[i] = r_state[i];
            w_hold_nxt[i]  = r_hold[i];
            hold_inc       = r_hold[i] + 1'b1;
            if (r_step) begin
                case (r_state[i])
                    ST_IDLE: begin
                        if (!r_s[i]) begin
                            w_state_nxt[i] = ST_HELD;
                            w_hold_nxt[i]  = '0;
                            w_post[i]      = 1'b1;
                        end
                    end
                    ST_HELD: begin
                        if (r_s[i]) begin
                            w_state_nxt[i] = ST_IDLE;
                        end else if (hold_inc == HW'(REPEAT_DELAY)) begin
                            w_state_nxt[i] = ST_RPT;
                            w_hold_nxt[i]  = '0;
                            w_post[i]      = 1'b1;
                            w_post_kind[i] = 1'b1;
                        end else begin
                            w_hold_nxt[i]  = hold_inc;
                        end
                    end
                    ST_RPT: begin
                        if (r_s[i]) begin
                            w_state_nxt[i] = ST_IDLE;
                        end else if (hold_inc == HW'(REPEAT_RATE)) begin
                            w_hold_nxt[i]  = '0;
                            w_post[i]      = 1'b1;
                            w_post_kind[i] = 1'b1;
                        end else begin
                            w_hold_nxt[i]  = hold_inc;
                        end
                    end
                    default: begin
                        w_state_nxt[i] = ST_IDLE;
                        w_hold_nxt[i]  = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < N; i++) begin
                r_state[i] <= ST_IDLE;
                r_hold[i]  <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < N; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_hold[i]  <= w_hold_nxt[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Pending events and round-robin arbiter
    // ------------------------------------------------------------------
    logic [N-1:0]  r_pend;
    logic [N-1:0]  r_kind;
    logic [IW-1:0] r_last;
    logic          w_free;
    logic          w_gnt_vld;
    logic [IW-1:0] w_gnt_id;
    logic          w_grant;
    logic [N-1:0]  w_clr;
    logic [N-1:0]  w_drop;

    assign w_free  = ~o_ev_valid | i_ev_ready;
    assign w_grant = w_free & w_gnt_vld;

    // Search starts just after the last winner, so a busy low index cannot
    // starve the others.
    always_comb begin
        int unsigned   idx;
        logic [IW-1:0] idx_t;
        idx       = 0;
        idx_t     = '0;
        w_gnt_vld = 1'b0;
        w_gnt_id  = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            idx   = (32'(r_last) + k) % N;
            idx_t = IW'(idx);
            if (!w_gnt_vld && r_pend[idx_t]) begin
                w_gnt_vld = 1'b1;
                w_gnt_id  = idx_t;
            end
        end
    end

    always_comb begin
        w_clr = '0;
        for (int unsigned i = 0; i < N; i++) begin
            w_clr[i] = w_grant && (w_gnt_id == IW'(i));
        end
    end

    // A post on the same edge as its own grant is a fresh event, not a drop.
    assign w_drop = w_post & r_pend & ~w_clr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend    <= '0;
            r_kind    <= '0;
            o_dropped <= 1'b0;
        end else begin
            r_pend    <= (r_pend & ~w_clr) | w_post;
            r_kind    <= (r_kind & ~w_post) | w_post_kind;
            o_dropped <= |w_drop;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_ev_valid <= 1'b0;
            o_ev_id    <= '0;
            o_ev_kind  <= 1'b0;
            r_last     <= IW'(N - 1);
        end else if (w_free) begin
            if (w_gnt_vld) begin
                o_ev_valid <= 1'b1;
                o_ev_id    <= w_gnt_id;
                o_ev_kind  <= r_kind[w_gnt_id];
                r_last     <= w_gnt_id;
            end else begin
                o_ev_valid <= 1'b0;
            end
        end
    end

endmodule
